// File: rtl/log_dump_ctrl.sv
// Capture-memory sequencer: arms a capture, waits for the memory to fill, then
// streams DUMP_LEN words from address 0 upward over a valid/ready link.
module log_dump_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 15,
  parameter int DUMP_LEN   = 32768,
  parameter int RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_cmd_capture,
  input  logic              i_cmd_dump,
  input  logic              i_cmd_abort,
  input  logic              i_mem_full,
  input  logic [DATA_W-1:0] i_data_log,
  output logic              o_run_log,
  output logic              o_read_log,
  output logic [ADDR_W-1:0] o_addr_log,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    FULL    = 3'd2,
    READ    = 3'd3,
    WAIT    = 3'd4,
    SEND    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DUMP_LEN - 1);
  localparam logic [2:0]        LAT_LOAD  = 3'(RD_LATENCY - 1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [2:0]          cnt_reg, cnt_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                run_reg, run_next;
  logic                read_reg, read_next;
  logic                valid_reg, valid_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    run_next   = 1'b0;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_cmd_dump && i_mem_full) begin
          addr_next  = '0;
          state_next = READ;
        end else if (i_cmd_capture) begin
          run_next   = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (i_cmd_abort) begin
          state_next = IDLE;
        end else if (i_mem_full) begin
          state_next = FULL;
        end
      end
      FULL: begin
        if (i_cmd_dump) begin
          addr_next  = '0;
          state_next = READ;
        end else if (i_cmd_capture) begin
          run_next   = 1'b1;
          state_next = CAPTURE;
        end
      end
      READ: begin
        cnt_next   = LAT_LOAD;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == 3'd0) begin
          data_next  = i_data_log;
          valid_next = 1'b1;
          state_next = SEND;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      SEND: begin
        if (valid_reg && i_ready) begin
          valid_next = 1'b0;
          if (addr_reg == LAST_ADDR) begin
            done_next  = 1'b1;
            state_next = FULL;
          end else begin
            addr_next  = addr_reg + 1'b1;
            state_next = READ;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort drops any pending word and parks in FULL so a fresh dump can follow.
    if (i_cmd_abort && (state_reg == READ || state_reg == WAIT || state_reg == SEND)) begin
      valid_next = 1'b0;
      done_next  = 1'b0;
      addr_next  = '0;
      state_next = FULL;
    end

    read_next = (state_next == READ) || (state_next == WAIT) || (state_next == SEND);
    busy_next = read_next || (state_next == CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      run_reg   <= 1'b0;
      read_reg  <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      run_reg   <= run_next;
      read_reg  <= read_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign o_run_log  = run_reg;
  assign o_read_log = read_reg;
  assign o_addr_log = addr_reg;
  assign o_data     = data_reg;
  assign o_valid    = valid_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;

endmodule
